// File: rtl/simon_pkg.sv
// Shared state encoding, default game parameters and symbol-to-LED decoding for the Simon controller.
// Pure declarations: no latency and no flow control.
package simon_pkg;

    localparam int unsigned MAX_ROUNDS_DEF    = 100;
    localparam int unsigned ON_TICKS_DEF      = 2;
    localparam int unsigned OFF_TICKS_DEF     = 1;
    localparam int unsigned TIMEOUT_TICKS_DEF = 16;

    localparam int unsigned IDX_W = 7;
    localparam int unsigned TMR_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        LOSE,
        WIN
    } state_t;

    // Symbol n lights key n.
    function automatic logic [3:0] decode(input logic [1:0] sym);
        logic [3:0] led;
        led      = 4'b0000;
        led[sym] = 1'b1;
        return led;
    endfunction

endpackage

// File: rtl/simon_round_ctrl_if.sv
// Game-side signal bundle: tick/start/key inputs, sequence-memory port and status outputs.
// No latency of its own; there is no backpressure, every pulse is a single-cycle event.
interface simon_round_ctrl_if;
    import simon_pkg::*;

    logic             tick;
    logic             start;
    logic [3:0]       key_press;
    logic [IDX_W-1:0] seq_addr;
    logic [1:0]       seq_data;
    logic [3:0]       key_leds;
    logic [IDX_W-1:0] round;
    logic             game_over;
    logic             win;

    modport master (
        output tick, start, key_press, seq_data,
        input  seq_addr, key_leds, round, game_over, win
    );

    modport slave (
        input  tick, start, key_press, seq_data,
        output seq_addr, key_leds, round, game_over, win
    );

endinterface

// File: rtl/phase_timer.sv
// Counts game ticks since the last clear; o_tc flags the tick that completes i_limit ticks.
// o_tc is combinational on the terminal tick; count updates one clk later. No backpressure.
module phase_timer
    import simon_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [TMR_W-1:0] i_limit,
    output logic             o_tc
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= r_cnt + TMR_W'(1);
        end
    end

    assign o_tc = i_tick && (r_cnt == (i_limit - TMR_W'(1)));

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round controller: plays back the stored sequence, then checks the player's presses against it.
// All outputs registered (one clk after the deciding input); game pace set by the external tick, no backpressure.
module simon_round_ctrl
    import simon_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS    = MAX_ROUNDS_DEF,
    parameter int unsigned ON_TICKS      = ON_TICKS_DEF,
    parameter int unsigned OFF_TICKS     = OFF_TICKS_DEF,
    parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    simon_round_ctrl_if.slave bus
);

    localparam logic [IDX_W-1:0] FINAL_ROUND = IDX_W'(MAX_ROUNDS);

    state_t           r_state;
    state_t           w_nxt;
    logic [IDX_W-1:0] r_round;
    logic [IDX_W-1:0] r_seq_addr;
    logic [IDX_W-1:0] w_round_nxt;
    logic [IDX_W-1:0] w_addr_nxt;
    logic [3:0]       r_key_leds;
    logic             r_game_over;
    logic             r_win;
    logic [3:0]       w_expect;
    logic             w_last;
    logic             w_restart;
    logic             w_clr;
    logic             w_tc;
    logic [TMR_W-1:0] w_limit;

    assign w_expect = decode(bus.seq_data);
    assign w_last   = (r_seq_addr == (r_round - IDX_W'(1)));

    always_comb begin
        w_limit = TMR_W'(TIMEOUT_TICKS);
        case (r_state)
            SHOW_ON:  w_limit = TMR_W'(ON_TICKS);
            SHOW_OFF: w_limit = TMR_W'(OFF_TICKS);
            default:  w_limit = TMR_W'(TIMEOUT_TICKS);
        endcase
    end

    // Terminal states hold the timer cleared so a restart always begins from zero.
    assign w_clr = (w_nxt != r_state) || w_restart ||
                   (r_state == IDLE) || (r_state == LOSE) || (r_state == WIN);

    phase_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_tick  (bus.tick),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt       = r_state;
        w_round_nxt = r_round;
        w_addr_nxt  = r_seq_addr;
        w_restart   = 1'b0;
        case (r_state)
            IDLE, LOSE, WIN: begin
                if (bus.start) begin
                    w_nxt       = SHOW_ON;
                    w_round_nxt = IDX_W'(1);
                    w_addr_nxt  = '0;
                end
            end
            SHOW_ON: begin
                if (w_tc) begin
                    w_nxt = SHOW_OFF;
                end
            end
            SHOW_OFF: begin
                if (w_tc) begin
                    if (!w_last) begin
                        w_addr_nxt = r_seq_addr + IDX_W'(1);
                        w_nxt      = SHOW_ON;
                    end else begin
                        w_addr_nxt = '0;
                        w_nxt      = WAIT_IN;
                    end
                end
            end
            WAIT_IN: begin
                // A press is judged before the timeout so it wins a same-cycle race.
                if (bus.key_press != 4'b0000) begin
                    if (bus.key_press != w_expect) begin
                        w_nxt = LOSE;
                    end else if (!w_last) begin
                        w_addr_nxt = r_seq_addr + IDX_W'(1);
                        w_restart  = 1'b1;
                    end else if (r_round == FINAL_ROUND) begin
                        w_nxt = WIN;
                    end else begin
                        w_round_nxt = r_round + IDX_W'(1);
                        w_addr_nxt  = '0;
                        w_nxt       = SHOW_ON;
                    end
                end else if (w_tc) begin
                    w_nxt = LOSE;
                end
            end
            default: begin
                w_nxt = IDLE;
            end
        endcase
    end

    // LEDs latch the symbol only while staying in SHOW_ON, so they go dark on the exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_round     <= '0;
            r_seq_addr  <= '0;
            r_key_leds  <= 4'b0000;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            r_round     <= w_round_nxt;
            r_seq_addr  <= w_addr_nxt;
            r_key_leds  <= ((r_state == SHOW_ON) && (w_nxt == SHOW_ON)) ? w_expect : 4'b0000;
            r_game_over <= (w_nxt == LOSE);
            r_win       <= (w_nxt == WIN);
        end
    end

    assign bus.seq_addr  = r_seq_addr;
    assign bus.round     = r_round;
    assign bus.key_leds  = r_key_leds;
    assign bus.game_over = r_game_over;
    assign bus.win       = r_win;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Bench for simon_round_ctrl: directed corner sequences, a press-outcome table and randomized games.
module tb_simon_round_ctrl;

    localparam int MR  = 3;
    localparam int ON  = 2;
    localparam int OFF = 1;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    simon_round_ctrl_if bus();
    logic [1:0] mem [0:127];
    assign bus.seq_data = mem[bus.seq_addr];

    simon_round_ctrl #(
        .MAX_ROUNDS    (MR),
        .ON_TICKS      (ON),
        .OFF_TICKS     (OFF),
        .TIMEOUT_TICKS (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] key;
        int         exp_round;
        int         exp_over;
    } press_vec_t;

    function automatic logic [3:0] exp_led(input logic [1:0] s);
        case (s)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic t, input logic s, input logic [3:0] k);
        bus.tick      = t;
        bus.start     = s;
        bus.key_press = k;
        @(posedge clk);
        #1;
        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.key_press = 4'b0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 4'b0000);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives ticks until round r's playback must be over, collecting each lit run of LEDs.
    task automatic playback(input int r, input bit stray);
        logic [3:0] runs[$];
        logic [3:0] prev;
        logic [3:0] k;
        logic       t;
        logic       s;
        int         ticks;
        int         guard;
        int         need;
        need  = r * (ON + OFF);
        ticks = 0;
        guard = 0;
        prev  = 4'b0000;
        while (ticks < need && guard < 2000) begin
            if (bus.key_leds != 4'b0000 && bus.key_leds != prev) runs.push_back(bus.key_leds);
            prev = bus.key_leds;
            t = ($urandom_range(0, 2) == 0);
            k = 4'b0000;
            s = 1'b0;
            if (stray && $urandom_range(0, 3) == 0) k = 4'($urandom_range(1, 15));
            if (stray && $urandom_range(0, 5) == 0) s = 1'b1;
            cyc(t, s, k);
            if (t) ticks++;
            guard++;
        end
        chk("playback_ticks", ticks, need);
        chk("playback_steps", runs.size(), r);
        for (int i = 0; i < runs.size() && i < r; i++)
            chk("playback_led", int'(runs[i]), int'(exp_led(mem[i])));
        chk("wait_round", int'(bus.round), r);
        chk("wait_addr", int'(bus.seq_addr), 0);
        chk("wait_leds", int'(bus.key_leds), 0);
    endtask

    // One game from a terminal/idle state; bad_r==0 means play perfectly to the win.
    task automatic play_game(input int bad_r, input int bad_i, input logic [3:0] bad_key);
        logic [3:0] k;
        cyc(1'b0, 1'b1, 4'b0000);
        chk("start_round", int'(bus.round), 1);
        chk("start_over", int'(bus.game_over), 0);
        chk("start_win", int'(bus.win), 0);
        for (int r = 1; r <= MR; r++) begin
            playback(r, 1'b1);
            for (int i = 0; i < r; i++) begin
                idle($urandom_range(0, 3));
                if (r == bad_r && i == bad_i) begin
                    k = bad_key;
                    while (k == 4'b0000 || k == exp_led(mem[i])) k = 4'($urandom_range(1, 15));
                    cyc(1'b0, 1'b0, k);
                    chk("lose_over", int'(bus.game_over), 1);
                    chk("lose_round", int'(bus.round), r);
                    chk("lose_leds", int'(bus.key_leds), 0);
                    chk("lose_win", int'(bus.win), 0);
                    return;
                end
                cyc(1'($urandom_range(0, 1)), 1'b0, exp_led(mem[i]));
                if (i < r - 1) begin
                    chk("press_addr", int'(bus.seq_addr), i + 1);
                    chk("press_over", int'(bus.game_over), 0);
                end else if (r < MR) begin
                    chk("next_round", int'(bus.round), r + 1);
                    chk("next_addr", int'(bus.seq_addr), 0);
                end else begin
                    chk("win_flag", int'(bus.win), 1);
                    chk("win_round", int'(bus.round), MR);
                    chk("win_over", int'(bus.game_over), 0);
                    chk("win_leds", int'(bus.key_leds), 0);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        press_vec_t tbl [7];
        int guard;

        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.key_press = 4'b0000;
        rst_n         = 1'b1;
        for (int i = 0; i < 128; i++) mem[i] = 2'($urandom_range(0, 3));
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;

        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_addr", int'(bus.seq_addr), 0);
        chk("rst_round", int'(bus.round), 0);
        chk("rst_leds", int'(bus.key_leds), 0);
        chk("rst_over", int'(bus.game_over), 0);
        chk("rst_win", int'(bus.win), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 4'b0001);
        chk("idle_ignores_keys", int'(bus.round), 0);

        // Full winning game on 2,0,3, then a round-2 miss with 0010 against 0001.
        play_game(0, 0, 4'b0000);
        play_game(2, 1, 4'b0010);

        tbl[0] = '{4'b0100, 2, 0};
        tbl[1] = '{4'b0001, 1, 1};
        tbl[2] = '{4'b0010, 1, 1};
        tbl[3] = '{4'b1000, 1, 1};
        tbl[4] = '{4'b0101, 1, 1};
        tbl[5] = '{4'b1111, 1, 1};
        tbl[6] = '{4'b0000, 1, 0};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            cyc(1'b0, 1'b1, 4'b0000);
            playback(1, 1'b0);
            cyc(1'b0, 1'b0, tbl[v].key);
            chk("tbl_round", int'(bus.round), tbl[v].exp_round);
            chk("tbl_over", int'(bus.game_over), tbl[v].exp_over);
            chk("tbl_win", int'(bus.win), 0);
            chk("tbl_leds", int'(bus.key_leds), 0);
        end

        // Timeout on the 16th idle tick; non-tick cycles in between must not count.
        do_reset();
        cyc(1'b0, 1'b1, 4'b0000);
        playback(1, 1'b0);
        for (int i = 0; i < TO - 1; i++) begin
            cyc(1'b1, 1'b0, 4'b0000);
            cyc(1'b0, 1'b0, 4'b0000);
        end
        chk("to_not_yet", int'(bus.game_over), 0);
        cyc(1'b1, 1'b0, 4'b0000);
        chk("to_fire", int'(bus.game_over), 1);
        chk("to_round", int'(bus.round), 1);
        chk("to_leds", int'(bus.key_leds), 0);

        cyc(1'b0, 1'b1, 4'b0000);
        chk("restart_over", int'(bus.game_over), 0);
        chk("restart_round", int'(bus.round), 1);
        playback(1, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b0, 1'b1, 4'b0000);
        chk("start_ignored_round", int'(bus.round), 1);
        chk("start_ignored_over", int'(bus.game_over), 0);
        cyc(1'b1, 1'b0, exp_led(mem[0]));
        chk("race_press_over", int'(bus.game_over), 0);
        chk("race_press_round", int'(bus.round), 2);

        // Asynchronous reset in the middle of a lit playback step.
        do_reset();
        cyc(1'b0, 1'b1, 4'b0000);
        guard = 0;
        while (bus.key_leds == 4'b0000 && guard < 50) begin
            cyc(1'b0, 1'b0, 4'b0000);
            guard++;
        end
        chk("mid_lit", int'(bus.key_leds), int'(exp_led(mem[0])));
        rst_n = 1'b0;
        #1;
        chk("async_addr", int'(bus.seq_addr), 0);
        chk("async_round", int'(bus.round), 0);
        chk("async_leds", int'(bus.key_leds), 0);
        chk("async_over", int'(bus.game_over), 0);
        chk("async_win", int'(bus.win), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'b0000);
        chk("post_rst_idle", int'(bus.round), 0);
        cyc(1'b0, 1'b1, 4'b0000);
        chk("post_rst_start", int'(bus.round), 1);
        playback(1, 1'b0);

        do_reset();
        for (int g = 0; g < 12; g++) begin
            for (int i = 0; i < MR; i++) mem[i] = 2'($urandom_range(0, 3));
            play_game($urandom_range(0, MR), 0, 4'b0000);
        end
        for (int g = 0; g < 6; g++) begin
            int br;
            for (int i = 0; i < MR; i++) mem[i] = 2'($urandom_range(0, 3));
            br = $urandom_range(1, MR);
            play_game(br, $urandom_range(0, br - 1), 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
